chart_sequencer: RTL and testbench



---
 rtl/mania_pkg.sv | 15 +
 rtl/tempo_tick.sv | 38 +++
 rtl/chart_sequencer.sv | 150 +++++++++++++++
 tb/tb_chart_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mania_pkg.sv
// Types shared by the chart sequencer, game control and the display.
package mania_pkg;

    localparam int LANES = 4;

    typedef logic [LANES-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/tempo_tick.sv
// Free-running row tempo counter: counts while enabled, clears on request,
// and flags the last tick of each row period.
module tempo_tick #(
    parameter int TICKS_PER_ROW = 1000000,
    parameter int TICK_W        = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_ROW - 1);

    logic [TICK_W-1:0] tick_cnt_d, tick_cnt_q;

    assign wrap = en && (tick_cnt_q == LAST_TICK);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clr || wrap) begin
            tick_cnt_d = '0;
        end else if (en) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/chart_sequencer.sv
// Steps through the chart ROM at a fixed tempo and hands each note row to the judge.
// Define CHART_LOOP_EN to replay the chart endlessly and expose loop_pulse.
module chart_sequencer
    import mania_pkg::*;
#(
    parameter int ROW_W         = 8,
    parameter int CHART_LEN     = 256,
    parameter int TICKS_PER_ROW = 1000000,
    parameter int TICK_W        = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    output logic [ROW_W-1:0] rom_addr,
    input  lane_vec_t        rom_data,
    output logic             note_valid,
    input  logic             note_ready,
    output lane_vec_t        note_lanes,
    output logic [ROW_W-1:0] row_idx,
    output logic             playing,
    output logic             done,
    output logic             overrun
`ifdef CHART_LOOP_EN
    ,
    output logic             loop_pulse
`endif
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHART_LEN - 1);

    seq_state_t       state_d, state_q;
    logic [ROW_W-1:0] row_ptr_d, row_ptr_q;
    logic [ROW_W-1:0] fetch_row_d, fetch_row_q;
    logic             fetch_pend_d, fetch_pend_q;
    logic             note_valid_d, note_valid_q;
    lane_vec_t        note_lanes_d, note_lanes_q;
    logic [ROW_W-1:0] row_idx_d, row_idx_q;
    logic             overrun_d, overrun_q;
    logic             wrap;
    logic             last_wrap;

    tempo_tick #(
        .TICKS_PER_ROW(TICKS_PER_ROW),
        .TICK_W       (TICK_W)
    ) u_tempo (
        .clk (clk),
        .rst (rst),
        .en  (state_q == PLAY),
        .clr (start),
        .wrap(wrap)
    );

    assign last_wrap = wrap && (row_ptr_q == LAST_ROW);

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        row_ptr_d    = row_ptr_q;
        fetch_row_d  = fetch_row_q;
        fetch_pend_d = 1'b0;
        note_valid_d = note_valid_q;
        note_lanes_d = note_lanes_q;
        row_idx_d    = row_idx_q;
        overrun_d    = overrun_q;

        if (start) begin
            state_d      = PLAY;
            row_ptr_d    = '0;
            note_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            if (wrap) begin
                fetch_pend_d = 1'b1;
                fetch_row_d  = row_ptr_q;
                row_ptr_d    = row_ptr_q + 1'b1;
            end

            // ROM data for the row addressed on the wrap cycle arrives one cycle later.
            if (fetch_pend_q) begin
                note_lanes_d = rom_data;
                row_idx_d    = fetch_row_q;
                note_valid_d = 1'b1;
                if (note_valid_q && !note_ready) begin
                    overrun_d = 1'b1;
                end
            end else if (note_valid_q && note_ready) begin
                note_valid_d = 1'b0;
            end

            case (state_q)
                PLAY: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end
`ifdef CHART_LOOP_EN
                    if (last_wrap) begin
                        row_ptr_d = '0;
                    end
`else
                    if (last_wrap) begin
                        state_d = DONE;
                    end
`endif
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_ptr_q    <= '0;
            fetch_row_q  <= '0;
            fetch_pend_q <= 1'b0;
            note_valid_q <= 1'b0;
            note_lanes_q <= '0;
            row_idx_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_ptr_q    <= row_ptr_d;
            fetch_row_q  <= fetch_row_d;
            fetch_pend_q <= fetch_pend_d;
            note_valid_q <= note_valid_d;
            note_lanes_q <= note_lanes_d;
            row_idx_q    <= row_idx_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rom_addr   = row_ptr_q;
    assign note_valid = note_valid_q;
    assign note_lanes = note_lanes_q;
    assign row_idx    = row_idx_q;
    assign overrun    = overrun_q;
    assign playing    = (state_q == PLAY);
    assign done       = (state_q == DONE);

`ifdef CHART_LOOP_EN
    assign loop_pulse = last_wrap && !start;
`endif

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed scoreboard bench for chart_sequencer with a short tempo and a 4-entry chart ROM.
module tb_chart_sequencer;
    import mania_pkg::*;

    localparam int ROW_W = 8;
    localparam int TICKS = 4;
`ifdef CHART_LOOP_EN
    localparam int TB_LEN = 2;
`else
    localparam int TB_LEN = 3;
`endif

    typedef struct {
        lane_vec_t lanes;
        int        idx;
        int        cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             note_ready = 1'b0;
    logic [ROW_W-1:0] rom_addr;
    lane_vec_t        rom_data = '0;
    logic             note_valid;
    lane_vec_t        note_lanes;
    logic [ROW_W-1:0] row_idx;
    logic             playing;
    logic             done;
    logic             overrun;
`ifdef CHART_LOOP_EN
    logic             loop_pulse;
`endif

    lane_vec_t rom [4];
    exp_t      sb[$];
    int        n_vec = 0;
    int        n_bad = 0;
    int        ncyc  = 0;
    int        base  = 0;

    chart_sequencer #(
        .ROW_W        (ROW_W),
        .CHART_LEN    (TB_LEN),
        .TICKS_PER_ROW(TICKS),
        .TICK_W       (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_lanes(note_lanes),
        .row_idx   (row_idx),
        .playing   (playing),
        .done      (done),
        .overrun   (overrun)
`ifdef CHART_LOOP_EN
        ,
        .loop_pulse(loop_pulse)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ncyc     <= ncyc + 1;
        rom_data <= rom[rom_addr[1:0]];
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, ncyc - base, act, exp);
        end
    endtask

    // Acceptance monitor: every accepted row must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && note_valid && note_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_accept @cycle %0d: row_idx %0d lanes %b", ncyc - base,
                         row_idx, note_lanes);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("accept_lanes", int'(note_lanes), int'(e.lanes));
                check("accept_row_idx", int'(row_idx), e.idx);
                check("accept_cycle", ncyc - base, e.cyc);
            end
        end
    end

    task automatic push(input lane_vec_t lanes, input int idx, input int cyc);
        exp_t e;
        e.lanes = lanes;
        e.idx   = idx;
        e.cyc   = cyc;
        sb.push_back(e);
    endtask

    task automatic at_cycle(input int k);
        while (ncyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        pause      = 1'b0;
        note_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic begin_song();
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = ncyc;
        at_cycle(1);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_note_valid"}, int'(note_valid), 0);
        check({tag, "_note_lanes"}, int'(note_lanes), 0);
        check({tag, "_row_idx"}, int'(row_idx), 0);
        check({tag, "_rom_addr"}, int'(rom_addr), 0);
        check({tag, "_playing"}, int'(playing), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rom[0] = 4'b0001;
        rom[1] = 4'b1010;
        rom[2] = 4'b0000;
        rom[3] = 4'b1111;

`ifdef CHART_LOOP_EN
        do_reset();
        note_ready = 1'b1;
        push(4'b0001, 0, 6);
        push(4'b1010, 1, 10);
        push(4'b0001, 0, 14);
        push(4'b1010, 1, 18);
        begin_song();
        at_cycle(4);
        check("loop_first_wrap_no_pulse", int'(loop_pulse), 0);
        at_cycle(8);
        check("loop_pulse_row1_wrap", int'(loop_pulse), 1);
        at_cycle(9);
        check("loop_pulse_one_cycle", int'(loop_pulse), 0);
        at_cycle(16);
        check("loop_pulse_second_pass", int'(loop_pulse), 1);
        at_cycle(19);
        check("loop_done_stays_0", int'(done), 0);
        check("loop_still_playing", int'(playing), 1);
        check("loop_sb_drained", sb.size(), 0);
`else
        // Full song, judge always ready.
        do_reset();
        check_reset_outputs("reset");
        note_ready = 1'b1;
        push(4'b0001, 0, 6);
        push(4'b1010, 1, 10);
        push(4'b0000, 2, 14);
        begin_song();
        check("s1_playing", int'(playing), 1);
        at_cycle(4);
        check("s1_rom_addr_wrap", int'(rom_addr), 0);
        at_cycle(5);
        check("s1_rom_addr_next", int'(rom_addr), 1);
        at_cycle(7);
        check("s1_valid_pulse_end", int'(note_valid), 0);
        at_cycle(12);
        check("s1_done_before_last", int'(done), 0);
        at_cycle(13);
        check("s1_done", int'(done), 1);
        check("s1_playing_off", int'(playing), 0);
        at_cycle(16);
        pause = 1'b1;
        at_cycle(19);
        check("s1_pause_ignored_done", int'(done), 1);
        pause = 1'b0;
        at_cycle(20);
        check("s1_overrun", int'(overrun), 0);
        check("s1_valid_idle", int'(note_valid), 0);
        check("s1_sb_drained", sb.size(), 0);

        // Judge stalls: overwrite and sticky overrun.
        do_reset();
        begin_song();
        at_cycle(6);
        check("s2_valid_row0", int'(note_valid), 1);
        check("s2_lanes_row0", int'(note_lanes), 4'b0001);
        at_cycle(9);
        check("s2_hold_lanes", int'(note_lanes), 4'b0001);
        check("s2_hold_idx", int'(row_idx), 0);
        check("s2_no_overrun_yet", int'(overrun), 0);
        at_cycle(10);
        check("s2_overwrite_lanes", int'(note_lanes), 4'b1010);
        check("s2_overwrite_idx", int'(row_idx), 1);
        check("s2_overrun_set", int'(overrun), 1);
        at_cycle(12);
        push(4'b1010, 1, 12);
        note_ready = 1'b1;
        at_cycle(13);
        note_ready = 1'b0;
        check("s2_valid_cleared", int'(note_valid), 0);
        check("s2_done", int'(done), 1);
        at_cycle(14);
        check("s2_final_fetch_valid", int'(note_valid), 1);
        check("s2_final_fetch_idx", int'(row_idx), 2);
        check("s2_overrun_sticky", int'(overrun), 1);
        check("s2_sb_drained", sb.size(), 0);

        // Pause freezes the tempo for six cycles.
        do_reset();
        note_ready = 1'b1;
        push(4'b0001, 0, 12);
        push(4'b1010, 1, 16);
        push(4'b0000, 2, 20);
        begin_song();
        at_cycle(3);
        pause = 1'b1;
        at_cycle(5);
        check("s3_paused_playing", int'(playing), 0);
        check("s3_paused_rom_addr", int'(rom_addr), 0);
        at_cycle(6);
        check("s3_no_early_valid", int'(note_valid), 0);
        at_cycle(9);
        pause = 1'b0;
        at_cycle(10);
        check("s3_resumed", int'(playing), 1);
        at_cycle(11);
        check("s3_not_yet_valid", int'(note_valid), 0);
        at_cycle(21);
        check("s3_done", int'(done), 1);
        check("s3_sb_drained", sb.size(), 0);

        // Restart mid-song with a row pending.
        do_reset();
        begin_song();
        at_cycle(10);
        check("s4_overrun_before", int'(overrun), 1);
        at_cycle(11);
        start = 1'b1;
        at_cycle(12);
        start = 1'b0;
        check("s4_valid_cleared", int'(note_valid), 0);
        check("s4_overrun_cleared", int'(overrun), 0);
        check("s4_playing", int'(playing), 1);
        at_cycle(16);
        check("s4_not_yet_valid", int'(note_valid), 0);
        at_cycle(17);
        check("s4_row0_valid", int'(note_valid), 1);
        check("s4_row0_idx", int'(row_idx), 0);
        check("s4_row0_lanes", int'(note_lanes), 4'b0001);
        push(4'b0001, 0, 17);
        push(4'b1010, 1, 21);
        push(4'b0000, 2, 25);
        note_ready = 1'b1;
        at_cycle(26);
        check("s4_no_overrun", int'(overrun), 0);
        check("s4_done", int'(done), 1);
        check("s4_sb_drained", sb.size(), 0);

        // Reset mid-song; start is ignored while reset is high.
        do_reset();
        begin_song();
        at_cycle(9);
        check("s5_valid_before_rst", int'(note_valid), 1);
        check("s5_rom_addr_before_rst", int'(rom_addr), 2);
        rst   = 1'b1;
        start = 1'b1;
        at_cycle(10);
        rst   = 1'b0;
        start = 1'b0;
        check_reset_outputs("s5");
        at_cycle(12);
        check("s5_start_ignored", int'(playing), 0);
        check("s5_sb_drained", sb.size(), 0);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
